// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: stage enables,
// flushes, operand forwarding and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rwe,
  input  logic             ex_is_load,
  input  logic [4:0]       mem_rd,
  input  logic             mem_rwe,
  input  logic             ex_redirect,
  input  logic             mem_access,
  input  logic             dmem_ack,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       busy_state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FLUSH    = 2'b10
  } state_t;

  localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES - 1);

  state_t           r_state;
  state_t           w_nxt;
  logic [2:0]       r_fcnt;
  logic [2:0]       w_fcnt_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wait;
  logic             w_lu;
  logic             w_ex_a;
  logic             w_ex_b;
  logic             w_mem_a;
  logic             w_mem_b;

  assign w_ex_a  = id_uses_rs1 && ex_rwe && !ex_is_load
                   && ex_rd != 5'd0 && ex_rd == id_rs1;
  assign w_ex_b  = id_uses_rs2 && ex_rwe && !ex_is_load
                   && ex_rd != 5'd0 && ex_rd == id_rs2;
  assign w_mem_a = id_uses_rs1 && mem_rwe
                   && mem_rd != 5'd0 && mem_rd == id_rs1;
  assign w_mem_b = id_uses_rs2 && mem_rwe
                   && mem_rd != 5'd0 && mem_rd == id_rs2;

  assign w_lu = ex_is_load && ex_rd != 5'd0
                && ((id_uses_rs1 && ex_rd == id_rs1)
                 || (id_uses_rs2 && ex_rd == id_rs2));

  assign w_wait = mem_access && !dmem_ack;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset) begin
      if (w_ex_a)       fwd_a = 2'b01;
      else if (w_mem_a) fwd_a = 2'b10;
      if (w_ex_b)       fwd_b = 2'b01;
      else if (w_mem_b) fwd_b = 2'b10;
    end
  end

  always_comb begin
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    id_ex_we    = 1'b0;
    ex_mem_we   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    w_nxt       = r_state;
    w_fcnt_nxt  = r_fcnt;
    if (reset) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      unique case (r_state)
        RUN, MEM_WAIT: begin
          // MEM_WAIT only leaves on ack; the frozen pipeline is re-evaluated then
          if ((r_state == RUN && w_wait)
              || (r_state == MEM_WAIT && !dmem_ack)) begin
            w_nxt = MEM_WAIT;
          end else if (ex_redirect) begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_fcnt_nxt  = FLUSH_LD;
            w_nxt       = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else if (w_lu) begin
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
            w_nxt       = RUN;
          end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            w_nxt     = RUN;
          end
        end
        FLUSH: begin
          if (!w_wait) begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_fcnt_nxt  = r_fcnt - 3'd1;
            if (r_fcnt <= 3'd1) w_nxt = RUN;
          end
        end
        default: w_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_fcnt  <= 3'd0;
    end else begin
      r_state <= w_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if ((!pc_we || if_id_flush) && r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign busy_state = r_state;
  assign stall_cnt  = r_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed cycles push expected
// controls, which are popped and compared mid-cycle.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic        ex_rwe, ex_is_load, mem_rwe;
  logic        ex_redirect, mem_access, dmem_ack;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic        if_id_flush, id_ex_flush;
  logic [1:0]  fwd_a, fwd_b, busy_state;
  logic [15:0] stall_cnt;
  logic        s_pc_we, s_if_id_we, s_id_ex_we, s_ex_mem_we;
  logic        s_if_id_flush, s_id_ex_flush;
  logic [1:0]  s_fwd_a, s_fwd_b, s_busy_state;
  logic [3:0]  s_stall_cnt;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_rwe(ex_rwe), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_rwe(mem_rwe),
    .ex_redirect(ex_redirect), .mem_access(mem_access),
    .dmem_ack(dmem_ack),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .busy_state(busy_state),
    .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_rwe(ex_rwe), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_rwe(mem_rwe),
    .ex_redirect(ex_redirect), .mem_access(mem_access),
    .dmem_ack(dmem_ack),
    .pc_we(s_pc_we), .if_id_we(s_if_id_we), .id_ex_we(s_id_ex_we),
    .ex_mem_we(s_ex_mem_we),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .busy_state(s_busy_state),
    .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] bs;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;
  int    m_cnt = 0;

  localparam logic [5:0] C_RUN = 6'b111100;
  localparam logic [5:0] C_FRZ = 6'b000000;
  localparam logic [5:0] C_FL  = 6'b111111;
  localparam logic [5:0] C_LU  = 6'b001101;
  localparam logic [5:0] C_RST = 6'b000011;
  localparam logic [1:0] S_RUN = 2'b00;
  localparam logic [1:0] S_MW  = 2'b01;
  localparam logic [1:0] S_FL  = 2'b10;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    reset = 0; id_rs1 = 0; id_rs2 = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = 0; ex_rwe = 0; ex_is_load = 0;
    mem_rd = 0; mem_rwe = 0;
    ex_redirect = 0; mem_access = 0; dmem_ack = 0;
  endtask

  // Called at the falling edge once inputs for this cycle are driven.
  task automatic step(input string tag, input logic [5:0] ctl,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic [1:0] bs);
    exp_t e;
    string t;
    sb_q.push_back('{ctl: ctl, fa: fa, fb: fb, bs: bs});
    tag_q.push_back(tag);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".ctl"}, {26'd0, pc_we, if_id_we, id_ex_we, ex_mem_we,
                      if_id_flush, id_ex_flush}, {26'd0, e.ctl});
    chk({t, ".fa"}, {30'd0, fwd_a}, {30'd0, e.fa});
    chk({t, ".fb"}, {30'd0, fwd_b}, {30'd0, e.fb});
    chk({t, ".st"}, {30'd0, busy_state}, {30'd0, e.bs});
    chk({t, ".cnt"}, {16'd0, stall_cnt}, m_cnt);
    chk({t, ".cnt4"}, {28'd0, s_stall_cnt}, (m_cnt > 15) ? 15 : m_cnt);
    if (reset) m_cnt = 0;
    else if (!e.ctl[5] || e.ctl[1]) m_cnt++;
    @(negedge clk);
  endtask

  task automatic lu_pat();
    ex_rd = 5'd7; ex_rwe = 1; ex_is_load = 1;
    id_rs1 = 5'd3; id_uses_rs1 = 1;
    id_rs2 = 5'd7; id_uses_rs2 = 1;
  endtask

  initial begin
    clr();
    reset = 1;
    @(negedge clk);
    ex_rd = 5'd5; ex_rwe = 1;
    id_rs1 = 5'd5; id_rs2 = 5'd5; id_uses_rs1 = 1; id_uses_rs2 = 1;
    step("reset", C_RST, 2'b00, 2'b00, S_RUN);

    reset = 0;
    step("fwd_ex", C_RUN, 2'b01, 2'b01, S_RUN);
    ex_rd = 5'd8; mem_rd = 5'd5; mem_rwe = 1;
    step("fwd_mem", C_RUN, 2'b10, 2'b10, S_RUN);
    ex_rd = 5'd5;
    step("fwd_prio", C_RUN, 2'b01, 2'b01, S_RUN);
    clr();
    id_uses_rs1 = 1; id_uses_rs2 = 1;
    ex_rwe = 1; mem_rwe = 1;
    step("fwd_x0", C_RUN, 2'b00, 2'b00, S_RUN);

    clr(); lu_pat();
    step("lu", C_LU, 2'b00, 2'b00, S_RUN);
    ex_rd = 0; ex_rwe = 0; ex_is_load = 0;
    mem_rd = 5'd7; mem_rwe = 1;
    step("lu_after", C_RUN, 2'b00, 2'b10, S_RUN);

    clr(); ex_redirect = 1;
    step("rd0", C_FL, 2'b00, 2'b00, S_RUN);
    step("rd1", C_FL, 2'b00, 2'b00, S_FL);
    clr();
    step("rd_end", C_RUN, 2'b00, 2'b00, S_RUN);

    mem_access = 1;
    step("mw0", C_FRZ, 2'b00, 2'b00, S_RUN);
    step("mw1", C_FRZ, 2'b00, 2'b00, S_MW);
    step("mw2", C_FRZ, 2'b00, 2'b00, S_MW);
    dmem_ack = 1;
    step("mw_ack", C_RUN, 2'b00, 2'b00, S_MW);
    clr();
    step("mw_end", C_RUN, 2'b00, 2'b00, S_RUN);

    mem_access = 1; ex_redirect = 1;
    step("wr0", C_FRZ, 2'b00, 2'b00, S_RUN);
    step("wr1", C_FRZ, 2'b00, 2'b00, S_MW);
    dmem_ack = 1;
    step("wr_ack", C_FL, 2'b00, 2'b00, S_MW);
    clr();
    step("wr_fl", C_FL, 2'b00, 2'b00, S_FL);
    step("wr_end", C_RUN, 2'b00, 2'b00, S_RUN);

    mem_access = 1; lu_pat();
    step("wl0", C_FRZ, 2'b00, 2'b00, S_RUN);
    dmem_ack = 1;
    step("wl_ack", C_LU, 2'b00, 2'b00, S_MW);
    clr();
    step("wl_end", C_RUN, 2'b00, 2'b00, S_RUN);

    lu_pat(); ex_redirect = 1;
    step("rvl", C_FL, 2'b00, 2'b00, S_RUN);
    clr(); mem_access = 1;
    step("fl_wait", C_FRZ, 2'b00, 2'b00, S_FL);
    dmem_ack = 1;
    step("fl_ack", C_FL, 2'b00, 2'b00, S_FL);
    clr();
    step("fl_end", C_RUN, 2'b00, 2'b00, S_RUN);

    ex_redirect = 1;
    step("rr0", C_FL, 2'b00, 2'b00, S_RUN);
    clr(); reset = 1;
    ex_rd = 5'd5; ex_rwe = 1; id_rs1 = 5'd5; id_uses_rs1 = 1;
    step("rr_rst", C_RST, 2'b00, 2'b00, S_FL);
    clr();
    step("rr_after", C_RUN, 2'b00, 2'b00, S_RUN);

    mem_access = 1;
    step("sat0", C_FRZ, 2'b00, 2'b00, S_RUN);
    for (int i = 0; i < 20; i++) begin
      step("sat", C_FRZ, 2'b00, 2'b00, S_MW);
    end
    #1;
    chk("sat_hold", {28'd0, s_stall_cnt}, 32'd15);
    chk("cnt_wide", {16'd0, stall_cnt}, 32'd21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
